// File: rtl/mips_muldiv_unit_if.sv
// Operand, move and result bundle between the MIPS datapath and the multiply/divide unit.
interface mips_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one shift-add or
// restoring-divide step per cycle on sign-stripped magnitudes, signs reapplied in FIX.
module mips_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic              clock,
    input logic              reset,
    mips_muldiv_unit_if.slave mdu
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q;
    logic                 is_div_q;
    logic                 neg_q;
    logic                 sign_a_q;
    logic                 b_zero_q;
    logic [WIDTH-1:0]     a_raw_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH:0]       rem_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 start_signed;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rmd;

    always_comb begin
        start_signed = ~mdu.op[0];
        a_mag = (start_signed && mdu.a[WIDTH-1]) ? -mdu.a : mdu.a;
        b_mag = (start_signed && mdu.b[WIDTH-1]) ? -mdu.b : mdu.b;

        // Multiply: acc low half holds the multiplier, opnd_q the multiplicand.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: acc low half shifts dividend bits out and quotient bits in.
        div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = div_shift >= {1'b0, opnd_q};

        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rmd  = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mdu.start) begin
                        is_div_q <= mdu.op[1];
                        neg_q    <= start_signed && (mdu.a[WIDTH-1] ^ mdu.b[WIDTH-1]);
                        sign_a_q <= start_signed && mdu.a[WIDTH-1];
                        b_zero_q <= (mdu.b == '0);
                        a_raw_q  <= mdu.a;
                        opnd_q   <= mdu.op[1] ? b_mag : a_mag;
                        acc_q    <= {{WIDTH{1'b0}}, (mdu.op[1] ? a_mag : b_mag)};
                        rem_q    <= '0;
                        cnt_q    <= CW'(WIDTH);
                        busy_q   <= 1'b1;
                        state_q  <= StCalc;
                    end else begin
                        if (mdu.hi_we) hi_q <= mdu.wdata;
                        if (mdu.lo_we) lo_q <= mdu.wdata;
                    end
                end
                StCalc: begin
                    if (is_div_q) begin
                        rem_q <= div_ge ? div_diff : div_shift;
                        acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_q <= mul_next;
                    end
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= StFix;
                end
                StFix: begin
                    if (is_div_q && b_zero_q) begin
                        lo_q <= '1;
                        hi_q <= a_raw_q;
                    end else if (is_div_q) begin
                        lo_q <= quo;
                        hi_q <= rmd;
                    end else begin
                        lo_q <= prod[WIDTH-1:0];
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                    end
                    dbz_q   <= is_div_q && b_zero_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mdu.busy        = busy_q;
    assign mdu.done        = done_q;
    assign mdu.div_by_zero = dbz_q;
    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: latency, products, quotients, moves, reset abort.
module tb_mips_muldiv_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    mips_muldiv_unit_if #(.WIDTH(32)) mdu ();

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .mdu   (mdu)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Launch an op in the current cycle; returns edges from start edge to done (34 expected).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int cyc, output logic dbz);
        logic [31:0] hi_prev;
        hi_prev   = mdu.hi;
        mdu.op    = op;
        mdu.a     = a;
        mdu.b     = b;
        mdu.start = 1'b1;
        @(posedge clock); #1;
        mdu.start = 1'b0;
        cyc = 1;
        check("busy_after_start", mdu.busy, 1);
        while (mdu.done !== 1'b1 && cyc < 100) begin
            if (disturb && cyc == 5) begin
                mdu.start = 1'b1;
                mdu.op    = 2'b10;
                mdu.a     = 32'h1111_1111;
                mdu.b     = 32'h2;
                mdu.hi_we = 1'b1;
                mdu.lo_we = 1'b1;
                mdu.wdata = 32'hCAFE_F00D;
            end
            @(posedge clock); #1;
            mdu.start = 1'b0;
            mdu.hi_we = 1'b0;
            mdu.lo_we = 1'b0;
            cyc++;
            if (cyc == 33) check("hi_held_during_calc", mdu.hi, hi_prev);
        end
        dbz = mdu.div_by_zero;
    endtask

    initial begin
        int   cyc;
        logic dbz;
        int   done_seen;
        mdu.start = 1'b0;
        mdu.op    = 2'b00;
        mdu.a     = '0;
        mdu.b     = '0;
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        mdu.wdata = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_busy", mdu.busy, 0);
        check("rst_done", mdu.done, 0);
        check("rst_dbz", mdu.div_by_zero, 0);
        check("rst_hi", mdu.hi, 0);
        check("rst_lo", mdu.lo, 0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, dbz);
        check("multu_latency", cyc, 34);
        check("multu_busy_done", mdu.busy, 0);
        check("multu_hi", mdu.hi, 32'hFFFF_FFFE);
        check("multu_lo", mdu.lo, 32'h0000_0001);
        check("multu_dbz", dbz, 0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, cyc, dbz);
        check("mult_hi", mdu.hi, 32'hFFFF_FFFF);
        check("mult_lo", mdu.lo, 32'hFFFF_FFEB);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, cyc, dbz);
        check("div_lo", mdu.lo, 32'hFFFF_FFFD);
        check("div_hi", mdu.hi, 32'hFFFF_FFFF);

        run_op(2'b11, 32'd100, 32'd7, 0, cyc, dbz);
        check("divu_lo", mdu.lo, 32'd14);
        check("divu_hi", mdu.hi, 32'd2);

        run_op(2'b11, 32'h1234, 32'h0, 0, cyc, dbz);
        check("dbz_latency", cyc, 34);
        check("dbz_lo", mdu.lo, 32'hFFFF_FFFF);
        check("dbz_hi", mdu.hi, 32'h1234);
        check("dbz_flag", dbz, 1);
        @(posedge clock); #1;
        check("dbz_flag_pulse", mdu.div_by_zero, 0);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, dbz);
        check("div_ovf_lo", mdu.lo, 32'h8000_0000);
        check("div_ovf_hi", mdu.hi, 32'h0);
        check("div_ovf_dbz", dbz, 0);

        run_op(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 0, cyc, dbz);
        check("mult_negneg_lo", mdu.lo, 32'd42);
        check("mult_negneg_hi", mdu.hi, 32'd0);

        // MTHI / MTLO in idle
        @(posedge clock); #1;
        mdu.hi_we = 1'b1;
        mdu.wdata = 32'hA5A5_A5A5;
        @(posedge clock); #1;
        mdu.hi_we = 1'b0;
        check("mthi_hi", mdu.hi, 32'hA5A5_A5A5);
        check("mthi_no_done", mdu.done, 0);
        mdu.lo_we = 1'b1;
        mdu.wdata = 32'h5A5A_0001;
        @(posedge clock); #1;
        mdu.lo_we = 1'b0;
        check("mtlo_lo", mdu.lo, 32'h5A5A_0001);
        check("mtlo_hi_kept", mdu.hi, 32'hA5A5_A5A5);
        mdu.hi_we = 1'b1;
        mdu.lo_we = 1'b1;
        mdu.wdata = 32'h0F0F_0F0F;
        @(posedge clock); #1;
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        check("mtboth_hi", mdu.hi, 32'h0F0F_0F0F);
        check("mtboth_lo", mdu.lo, 32'h0F0F_0F0F);

        // start and moves while busy are ignored
        run_op(2'b01, 32'd3, 32'd5, 1, cyc, dbz);
        check("busy_ign_latency", cyc, 34);
        check("busy_ign_lo", mdu.lo, 32'd15);
        check("busy_ign_hi", mdu.hi, 32'd0);

        // back-to-back start in the done cycle
        run_op(2'b01, 32'd9, 32'd11, 0, cyc, dbz);
        check("b2b_first_latency", cyc, 34);
        check("b2b_first_lo", mdu.lo, 32'd99);
        run_op(2'b11, 32'd50, 32'd8, 0, cyc, dbz);
        check("b2b_second_latency", cyc, 34);
        check("b2b_second_lo", mdu.lo, 32'd6);
        check("b2b_second_hi", mdu.hi, 32'd2);

        // start wins over a simultaneous move
        @(posedge clock); #1;
        mdu.hi_we = 1'b1;
        mdu.wdata = 32'hDEAD_BEEF;
        run_op(2'b01, 32'd2, 32'd3, 0, cyc, dbz);
        check("start_wins_hi", mdu.hi, 32'd0);
        check("start_wins_lo", mdu.lo, 32'd6);

        // reset mid-operation aborts with no done
        @(posedge clock); #1;
        mdu.op    = 2'b00;
        mdu.a     = 32'h1234_5678;
        mdu.b     = 32'h9;
        mdu.start = 1'b1;
        @(posedge clock); #1;
        mdu.start = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_busy", mdu.busy, 0);
        check("abort_hi", mdu.hi, 0);
        check("abort_lo", mdu.lo, 0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (mdu.done === 1'b1) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_op(2'b01, 32'd6, 32'd7, 0, cyc, dbz);
        check("after_abort_latency", cyc, 34);
        check("after_abort_lo", mdu.lo, 32'd42);
        check("after_abort_hi", mdu.hi, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
